// File: rtl/input_conditioner_n.sv
// N-channel interlock input conditioner: synchroniser, debounce, edge pulses,
// sticky fault latches and first-fault capture, all on the divided clock.
module input_conditioner_n #(
   parameter int                NUM_CH          = 43,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = 16,
   parameter logic [NUM_CH-1:0] RESET_VAL       = '0,
   parameter logic [NUM_CH-1:0] LATCH_MASK      = '1,
   localparam int               CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   localparam int               ID_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] in_raw,
   input  logic              clear_latch,
   output logic [NUM_CH-1:0] out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] latched,
   output logic              any_fault,
   output logic              first_fault_valid,
   output logic [ID_W-1:0]   first_fault_id
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_d  [NUM_CH];
   logic [NUM_CH-1:0] s;
   logic [NUM_CH-1:0] out_q, out_d;
   logic [NUM_CH-1:0] rise_q, fall_q;
   logic [NUM_CH-1:0] latched_q, latched_d;
   logic              ffv_q, ffv_d;
   logic [ID_W-1:0]   ffid_q, ffid_d;
   logic [ID_W-1:0]   lowest_id;

   assign s = sync_q[SYNC_STAGES-1];

   // A single sample matching the current output restarts the stability count.
   always_comb begin
      out_d = out_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            out_d[i] = s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Set beats clear: a channel still asserted keeps its latch through a clear request.
   always_comb begin
      latched_d = (out_q | (latched_q & ~{NUM_CH{clear_latch}})) & LATCH_MASK;
      lowest_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (latched_d[i]) lowest_id = ID_W'(i);
      end
      ffv_d  = ffv_q;
      ffid_d = ffid_q;
      if (!ffv_q && (latched_d != '0)) begin
         ffv_d  = 1'b1;
         ffid_d = lowest_id;
      end else if (clear_latch && ((out_q & LATCH_MASK) == '0)) begin
         ffv_d  = 1'b0;
         ffid_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         out_q     <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         latched_q <= '0;
         ffv_q     <= 1'b0;
         ffid_q    <= '0;
      end else begin
         sync_q[0] <= in_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
         out_q     <= out_d;
         rise_q    <= out_d & ~out_q;
         fall_q    <= ~out_d & out_q;
         latched_q <= latched_d;
         ffv_q     <= ffv_d;
         ffid_q    <= ffid_d;
      end
   end

   assign out               = out_q;
   assign rise              = rise_q;
   assign fall              = fall_q;
   assign latched           = latched_q;
   assign any_fault         = |latched_q;
   assign first_fault_valid = ffv_q;
   assign first_fault_id    = ffid_q;

endmodule

// File: tb/tb_input_conditioner_n.sv
// Bench for input_conditioner_n: window-based reference model checked every cycle
// on two instances (reset value 0 and 4'b0001), plus literal spot checks.
module tb_input_conditioner_n;

   localparam int         NCH  = 4;
   localparam int         SYNC = 2;
   localparam int         DEB  = 4;
   localparam logic [3:0] MASK = 4'b1011;
   localparam logic [3:0] RV_A = 4'b0000;
   localparam logic [3:0] RV_B = 4'b0001;

   typedef struct packed {
      logic [SYNC-1:0][3:0] sync;
      logic [DEB-1:0][3:0]  hist;
      logic [3:0]           out;
      logic [3:0]           rise;
      logic [3:0]           fall;
      logic [3:0]           lat;
      logic                 ffv;
      logic [1:0]           ffid;
   } mst_t;

   logic       clk = 1'b0;
   logic       reset_a = 1'b1, clear_a = 1'b0;
   logic       reset_b = 1'b1, clear_b = 1'b0;
   logic [3:0] in_a = 4'b0, in_b = 4'b0;
   logic [3:0] a_out, a_rise, a_fall, a_lat;
   logic [3:0] b_out, b_rise, b_fall, b_lat;
   logic       a_any, a_ffv, b_any, b_ffv;
   logic [1:0] a_ffid, b_ffid;
   mst_t       ma, mb;
   logic       chk_en = 1'b0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   input_conditioner_n #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                         .RESET_VAL(RV_A), .LATCH_MASK(MASK)) dut_a (
      .clk(clk), .reset(reset_a), .in_raw(in_a), .clear_latch(clear_a),
      .out(a_out), .rise(a_rise), .fall(a_fall), .latched(a_lat),
      .any_fault(a_any), .first_fault_valid(a_ffv), .first_fault_id(a_ffid));

   input_conditioner_n #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                         .RESET_VAL(RV_B), .LATCH_MASK(MASK)) dut_b (
      .clk(clk), .reset(reset_b), .in_raw(in_b), .clear_latch(clear_b),
      .out(b_out), .rise(b_rise), .fall(b_fall), .latched(b_lat),
      .any_fault(b_any), .first_fault_valid(b_ffv), .first_fault_id(b_ffid));

   // Output flips only once the last DEB synchronised samples all disagree with it.
   function automatic mst_t mstep(mst_t m, logic [3:0] in, logic rst, logic clr, logic [3:0] rv);
      mst_t       n;
      logic [3:0] s;
      logic [3:0] o;
      logic       all_diff;
      n = m;
      if (rst) begin
         n.sync = {SYNC{rv}};
         n.hist = {DEB{rv}};
         n.out  = rv;
         n.rise = '0;
         n.fall = '0;
         n.lat  = '0;
         n.ffv  = 1'b0;
         n.ffid = '0;
         return n;
      end
      s      = m.sync[SYNC-1];
      n.hist = {m.hist[DEB-2:0], s};
      o      = m.out;
      for (int i = 0; i < NCH; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DEB; j++) if (n.hist[j][i] == m.out[i]) all_diff = 1'b0;
         if (all_diff) o[i] = s[i];
      end
      n.out  = o;
      n.rise = o & ~m.out;
      n.fall = ~o & m.out;
      n.sync = {m.sync[SYNC-2:0], in};
      n.lat  = (m.out | (m.lat & ~{4{clr}})) & MASK;
      if (!m.ffv && n.lat != 4'b0) begin
         n.ffv = 1'b1;
         for (int i = NCH - 1; i >= 0; i--) if (n.lat[i]) n.ffid = 2'(i);
      end else if (clr && (m.out & MASK) == 4'b0) begin
         n.ffv  = 1'b0;
         n.ffid = '0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma <= mstep(ma, in_a, reset_a, clear_a, RV_A);
      mb <= mstep(mb, in_b, reset_b, clear_b, RV_B);
   end

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a.out", 32'(a_out), 32'(ma.out));
         cmp("a.rise", 32'(a_rise), 32'(ma.rise));
         cmp("a.fall", 32'(a_fall), 32'(ma.fall));
         cmp("a.latched", 32'(a_lat), 32'(ma.lat));
         cmp("a.any_fault", 32'(a_any), 32'(ma.lat != 4'b0));
         cmp("a.ffv", 32'(a_ffv), 32'(ma.ffv));
         cmp("a.ffid", 32'(a_ffid), 32'(ma.ffid));
         cmp("b.out", 32'(b_out), 32'(mb.out));
         cmp("b.rise", 32'(b_rise), 32'(mb.rise));
         cmp("b.fall", 32'(b_fall), 32'(mb.fall));
         cmp("b.latched", 32'(b_lat), 32'(mb.lat));
         cmp("b.any_fault", 32'(b_any), 32'(mb.lat != 4'b0));
         cmp("b.ffv", 32'(b_ffv), 32'(mb.ffv));
         cmp("b.ffid", 32'(b_ffid), 32'(mb.ffid));
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear_a();
      clear_a = 1'b1;
      step(1);
      clear_a = 1'b0;
   endtask

   initial begin
      step(2);
      chk_en = 1'b1;
      cmp("reset out", 32'(a_out), 32'h0);
      cmp("reset latched", 32'(a_lat), 32'h0);
      cmp("reset ffv", 32'(a_ffv), 32'h0);
      reset_a = 1'b0;
      step(2);

      // glitch of 3 samples is rejected
      in_a[0] = 1'b1;
      step(3);
      in_a[0] = 1'b0;
      step(8);
      cmp("glitch out0", 32'(a_out[0]), 32'h0);
      cmp("glitch latched0", 32'(a_lat[0]), 32'h0);
      in_a[0] = 1'b1;
      step(5);
      cmp("ch0 out before k+5", 32'(a_out[0]), 32'h0);
      step(1);
      cmp("ch0 out at k+5", 32'(a_out[0]), 32'h1);
      cmp("ch0 rise at k+5", 32'(a_rise[0]), 32'h1);
      step(1);
      cmp("ch0 latched at k+6", 32'(a_lat[0]), 32'h1);
      cmp("ch0 ffid", 32'(a_ffid), 32'h0);
      in_a[0] = 1'b0;
      step(8);
      pulse_clear_a();
      cmp("ch0 cleared ffv", 32'(a_ffv), 32'h0);

      // clean edge on ch1, then hold-error clear
      in_a[1] = 1'b1;
      step(6);
      cmp("ch1 out at k+5", 32'(a_out[1]), 32'h1);
      cmp("ch1 rise at k+5", 32'(a_rise[1]), 32'h1);
      step(1);
      cmp("ch1 rise drop", 32'(a_rise[1]), 32'h0);
      cmp("ch1 latched", 32'(a_lat[1]), 32'h1);
      cmp("ch1 any_fault", 32'(a_any), 32'h1);
      cmp("ch1 ffv", 32'(a_ffv), 32'h1);
      cmp("ch1 ffid", 32'(a_ffid), 32'h1);
      pulse_clear_a();
      cmp("clear while high latched1", 32'(a_lat[1]), 32'h1);
      cmp("clear while high ffv", 32'(a_ffv), 32'h1);
      in_a[1] = 1'b0;
      step(8);
      pulse_clear_a();
      cmp("cleared latched", 32'(a_lat), 32'h0);
      cmp("cleared any_fault", 32'(a_any), 32'h0);
      cmp("cleared ffv", 32'(a_ffv), 32'h0);
      cmp("cleared ffid", 32'(a_ffid), 32'h0);

      // simultaneous ch0/ch3, frozen id, masked ch2
      in_a = 4'b1001;
      step(7);
      cmp("simul ffv", 32'(a_ffv), 32'h1);
      cmp("simul ffid", 32'(a_ffid), 32'h0);
      in_a[3] = 1'b0;
      step(8);
      in_a[3] = 1'b1;
      step(8);
      cmp("ch3 relatch ffid", 32'(a_ffid), 32'h0);
      in_a[2] = 1'b1;
      step(8);
      cmp("masked out2", 32'(a_out[2]), 32'h1);
      cmp("masked latched2", 32'(a_lat[2]), 32'h0);
      in_a = 4'b0000;
      step(8);
      pulse_clear_a();

      // reset mid-debounce with ch1 latched
      in_a[1] = 1'b1;
      step(8);
      cmp("pre-reset latched1", 32'(a_lat[1]), 32'h1);
      in_a[0] = 1'b1;
      step(4);
      reset_a = 1'b1;
      step(1);
      cmp("mid reset out", 32'(a_out), 32'h0);
      cmp("mid reset latched", 32'(a_lat), 32'h0);
      cmp("mid reset ffv", 32'(a_ffv), 32'h0);
      reset_a = 1'b0;
      step(5);
      cmp("restart out0 early", 32'(a_out[0]), 32'h0);
      step(1);
      cmp("restart out0 at k+5", 32'(a_out[0]), 32'h1);
      step(4);

      // nonzero reset value instance
      cmp("b out during reset", 32'(b_out), 32'h1);
      cmp("b latched during reset", 32'(b_lat), 32'h0);
      in_b[0] = 1'b1;
      reset_b = 1'b0;
      step(1);
      cmp("b latched0 after release", 32'(b_lat[0]), 32'h1);
      cmp("b ffv after release", 32'(b_ffv), 32'h1);
      cmp("b fall quiet", 32'(b_fall[0]), 32'h0);
      step(3);
      in_b[0] = 1'b0;
      step(5);
      cmp("b fall before k+5", 32'(b_fall[0]), 32'h0);
      step(1);
      cmp("b fall at k+5", 32'(b_fall[0]), 32'h1);
      cmp("b out0 at k+5", 32'(b_out[0]), 32'h0);
      step(1);
      cmp("b fall drop", 32'(b_fall[0]), 32'h0);
      step(2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_conditioner_n.md
Name: input_conditioner_n

Overview:
Parametrised N-channel input conditioning stage for the RPSC interlock inputs. It replaces the one-flop-per-pin input capture with:
- a configurable synchroniser chain per channel
- a per-channel debounce counter
- edge pulses
- sticky fault latches with hold-error clear semantics
- first-fault capture for the alarm/LED logic.

It sits between the raw FPGA pins and the interlock card logic, in the divided-clock domain.

Parameters:
NUM_CH, 43, number of input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable samples required before out changes (>=1)
RESET_VAL, all 0 (NUM_CH bits), per-channel reset value of sync chain and out
LATCH_MASK, all 1 (NUM_CH bits), channels that feed the fault latches / first-fault logic
Derived localparams: CNT_W = clog2(DEBOUNCE_CYCLES+1); ID_W = max(1, clog2(NUM_CH)).

Ports:
clk  in  1  divided system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
in_raw  in  NUM_CH  asynchronous raw pin levels
clear_latch  in  1  hold-error clear request (level, sampled each clk)
out  out  NUM_CH  debounced, synchronised levels
rise  out  NUM_CH  1-cycle pulse when out[i] goes 0->1
fall  out  NUM_CH  1-cycle pulse when out[i] goes 1->0
latched  out  NUM_CH  sticky fault flags (masked channels only)
any_fault  out  1  OR of latched
first_fault_valid  out  1  first_fault_id holds a captured channel
first_fault_id  out  ID_W  index of first channel to latch since last clear

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset values:
  - sync chain[i] = RESET_VAL[i]; out = RESET_VAL
  - counters = 0; rise = fall = 0
  - latched = 0; first_fault_valid = 0; first_fault_id = 0
  - Reset asserted mid-debounce discards any partial count.
- Synchroniser: s[i] is the last stage of the SYNC_STAGES chain. It is never used before the last stage.
- Debounce, per channel, each edge:
  - If s[i] == out[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: out[i] <= s[i]; cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any single sample equal to out restarts the count. A glitch shorter than DEBOUNCE_CYCLES samples never reaches out.
- Latency: if edge k is the first edge sampling the new in_raw level and the level is held, out changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1 that is edge k+SYNC_STAGES.
- rise/fall: registered. Asserted for exactly the cycle in which out first shows the new value; deasserted otherwise. They are never both high for one channel.
- latched[i], LATCH_MASK[i]=1, level-sensitive on out:
  - Next value = out[i] | (latched[i] & ~clear_latch).
  - Set wins over clear, so clear_latch while out[i]=1 leaves latched[i]=1.
  - latched[i] rises one cycle after out[i] rises.
  - If RESET_VAL[i]=1, latched[i] sets on the first edge after reset deasserts.
- latched[i], LATCH_MASK[i]=0: tied 0.
- any_fault: combinational OR of latched registers (no extra latency).
- First fault, evaluated with the same next-state as latched:
  - Capture: if first_fault_valid=0 and any masked channel's latched next-state is 1, then first_fault_valid <= 1 and first_fault_id <= lowest such index. With clear_latch=0, no latched bit is set while first_fault_valid=0.
  - Clear: if clear_latch=1 and (out & LATCH_MASK)==0, then first_fault_valid <= 0 and first_fault_id <= 0.
  - Neither: hold.
  - While first_fault_valid=1, id is frozen, even if other channels latch.
- Clear-and-capture in the same cycle: if clear_latch=1 with an active masked out bit, valid is not cleared. If valid was 0, capture proceeds using the lowest active index.

Test Plan:
(NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0, LATCH_MASK=4'b1011, unless stated)
1. Glitch rejection: in_raw[0] high for 3 cycles, then low -> out[0], rise[0], latched[0] stay 0 throughout. Then hold high 4 cycles -> out[0]=1 at edge k+5.
2. Clean edge: in_raw[1] 0->1 first sampled at edge k -> out[1]=1 and rise[1]=1 for one cycle at edge k+5. At k+6: latched[1]=1, any_fault=1, first_fault_valid=1, first_fault_id=1.
3. Simultaneous plus mask:
   - in_raw[0] and in_raw[3] rise on the same cycle -> first_fault_id=0.
   - Later, ch3 deasserts, debounces, then reasserts -> first_fault_id stays 0.
   - in_raw[2] high -> latched[2] stays 0 (masked off).
4. Hold-error clear:
   - clear_latch pulse while out[1]=1 -> latched[1] and first_fault_valid stay 1.
   - Drop in_raw[1]; after out[1]=0, pulse clear_latch -> next cycle latched=0, any_fault=0, first_fault_valid=0, id=0.
5. Reset mid-operation: assert reset at cnt=2 on ch0 with latched[1]=1 -> next cycle all outputs 0. Deassert with in_raw[0] still high -> out[0]=1 at edge 5 after first sample (full restart).
6. RESET_VAL=4'b0001 -> out[0]=1 during reset; latched[0]=1 one edge after reset release; fall[0] pulses only after in_raw[0]=0 is debounced.
